// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared state encoding, default width and counter sizing for the restoring divider
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam int DEFAULT_WIDTH = 8;

    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/cla_subtractor.sv
// rtl/cla_subtractor.sv - carry-look-ahead subtractor a + ~b + 1, borrow = ~carry_out
module cla_subtractor #(
    parameter int N = 9
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] diff,
    output logic         borrow
);

    localparam logic CIN = 1'b1;

    logic [N-1:0] g;
    logic [N-1:0] p;
    logic [N:0]   c;

    assign g = a & ~b;
    assign p = a ^ ~b;

    // Each carry is expanded as a flat generate/propagate sum, not a ripple chain.
    always_comb begin
        logic carry;
        logic prop;
        carry = 1'b0;
        prop  = 1'b1;
        c     = '0;
        c[0]  = CIN;
        for (int i = 0; i < N; i++) begin
            carry = 1'b0;
            prop  = 1'b1;
            for (int j = i; j >= 0; j--) begin
                carry = carry | (prop & g[j]);
                prop  = prop & p[j];
            end
            c[i+1] = carry | (prop & CIN);
        end
    end

    assign diff   = p ^ c[N-1:0];
    assign borrow = ~c[N];

endmodule

// File: rtl/seq_restoring_divider.sv
// rtl/seq_restoring_divider.sv - one-bit-per-cycle restoring divider; SIGNED_DIV_EN adds signed mode
module seq_restoring_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
`ifdef SIGNED_DIV_EN
    input  logic             div_signed,
`endif
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = cnt_width(WIDTH);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH:0]   t;
    logic [WIDTH:0]   diff;
    logic             borrow;
    logic             diff_msb_unused;
    logic [WIDTH-1:0] r_step;
    logic [WIDTH-1:0] q_step;

`ifdef SIGNED_DIV_EN
    logic neg_q_q, neg_q_d;
    logic neg_r_q, neg_r_d;
    logic dvd_neg;
    logic dvs_neg;

    // Signed operands run through the unsigned datapath as magnitudes; FIX restores signs.
    assign dvd_neg = div_signed & dividend[WIDTH-1];
    assign dvs_neg = div_signed & divisor[WIDTH-1];
    assign dvd_mag = dvd_neg ? -dividend : dividend;
    assign dvs_mag = dvs_neg ? -divisor  : divisor;
`else
    assign dvd_mag = dividend;
    assign dvs_mag = divisor;
`endif

    assign t = {r_q, q_q[WIDTH-1]};

    cla_subtractor #(
        .N(WIDTH + 1)
    ) u_sub (
        .a      (t),
        .b      ({1'b0, dvsr_q}),
        .diff   (diff),
        .borrow (borrow)
    );

    // A successful subtraction always leaves D below the divisor, so its top bit is zero.
    assign diff_msb_unused = diff[WIDTH];
    assign r_step = borrow ? t[WIDTH-1:0] : diff[WIDTH-1:0];
    assign q_step = {q_q[WIDTH-2:0], ~borrow};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        q_d     = q_q;
        dvsr_d  = dvsr_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
`ifdef SIGNED_DIV_EN
        neg_q_d = neg_q_q;
        neg_r_d = neg_r_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    dvsr_d = dvs_mag;
                    r_d    = '0;
                    q_d    = dvd_mag;
                    cnt_d  = '0;
`ifdef SIGNED_DIV_EN
                    neg_q_d = dvd_neg ^ dvs_neg;
                    neg_r_d = dvd_neg;
`endif
                    if (divisor == '0) begin
                        quot_d  = '1;
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                r_d   = r_step;
                q_d   = q_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
`ifdef SIGNED_DIV_EN
                    state_d = FIX;
`else
                    quot_d  = q_step;
                    rem_d   = r_step;
                    dbz_d   = 1'b0;
                    state_d = DONE;
`endif
                end
            end
`ifdef SIGNED_DIV_EN
            FIX: begin
                quot_d  = neg_q_q ? -q_q : q_q;
                rem_d   = neg_r_q ? -r_q : r_q;
                dbz_d   = 1'b0;
                state_d = DONE;
            end
`endif
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            r_q     <= '0;
            q_q     <= '0;
            dvsr_q  <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
`ifdef SIGNED_DIV_EN
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            q_q     <= q_d;
            dvsr_q  <= dvsr_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
`ifdef SIGNED_DIV_EN
            neg_q_q <= neg_q_d;
            neg_r_q <= neg_r_d;
`endif
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// tb/tb_seq_restoring_divider.sv - self-checking bench: arithmetic reference model plus directed vectors
module tb_seq_restoring_divider;

    localparam int W = 8;
`ifdef SIGNED_DIV_EN
    localparam int SX = 1;
`else
    localparam int SX = 0;
`endif
    localparam int LAT = W + 1 + SX;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         sgn = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_restoring_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
`ifdef SIGNED_DIV_EN
        .div_signed  (sgn),
`endif
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: plain integer division, with the divide-by-zero convention.
    function automatic logic [2*W:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        int sa;
        int sb;
        logic [W-1:0] q;
        logic [W-1:0] r;
        if (b == '0) return {1'b1, {W{1'b1}}, a};
        if (s) begin
            sa = int'($signed(a));
            sb = int'($signed(b));
            q  = W'(sa / sb);
            r  = W'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {1'b0, q, r};
    endfunction

    int           m_left = 0;
    logic [W-1:0] m_quot = '0;
    logic [W-1:0] m_rem = '0;
    logic         m_dbz = 1'b0;
    logic [2*W:0] m_pend = '0;

    // Model: cycles remaining until done; results appear with done and persist.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left <= 0;
            m_quot <= '0;
            m_rem  <= '0;
            m_dbz  <= 1'b0;
        end else if (m_left == 0) begin
            if (start) begin
                m_pend <= ref_div(dividend, divisor, sgn);
                m_left <= (divisor == '0) ? 1 : LAT;
                if (divisor == '0) begin
                    {m_dbz, m_quot, m_rem} <= ref_div(dividend, divisor, sgn);
                end
            end
        end else begin
            m_left <= m_left - 1;
            if (m_left == 2) {m_dbz, m_quot, m_rem} <= m_pend;
        end
    end

    always @(negedge clk) begin
        chk("cyc_busy", busy, m_left != 0);
        chk("cyc_done", done, m_left == 1);
        chk("cyc_quot", quotient, m_quot);
        chk("cyc_rem", remainder, m_rem);
        chk("cyc_dbz", div_by_zero, m_dbz);
    end

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        @(posedge clk);
        #1;
        dividend = a;
        divisor  = b;
        sgn      = s;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (done) begin
                lat = k;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL wait_done: no done within 40 cycles, required done=1");
    endtask

    task automatic run_case(input string nm, input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                            input logic [W-1:0] eq, input logic [W-1:0] er, input logic ez, input int elat);
        int lat;
        issue(a, b, s);
        wait_done(lat);
        chk({nm, "_lat"}, lat, elat);
        chk({nm, "_quot"}, quotient, eq);
        chk({nm, "_rem"}, remainder, er);
        chk({nm, "_dbz"}, div_by_zero, ez);
    endtask

    initial begin
        int lat;
        int n;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_quot", quotient, 0);
        chk("rst_rem", remainder, 0);
        chk("rst_dbz", div_by_zero, 0);
        rst_n = 1'b1;

        run_case("200/7", 8'd200, 8'd7, 1'b0, 8'd28, 8'd4, 1'b0, LAT);

        @(posedge clk);
        #1;
        dividend = 8'd255;
        divisor  = 8'd1;
        start    = 1'b1;
        wait_done(lat);
        chk("b2b1_quot", quotient, 8'd255);
        chk("b2b1_rem", remainder, 8'd0);
        dividend = 8'd3;
        divisor  = 8'd10;
        wait_done(lat);
        start = 1'b0;
        chk("b2b_gap", lat, W + 2 + SX);
        chk("b2b2_quot", quotient, 8'd0);
        chk("b2b2_rem", remainder, 8'd3);

        run_case("5/0", 8'd5, 8'd0, 1'b0, 8'hFF, 8'd5, 1'b1, 1);
        run_case("9/3", 8'd9, 8'd3, 1'b0, 8'd3, 8'd0, 1'b0, LAT);
        run_case("7/200", 8'd7, 8'd200, 1'b0, 8'd0, 8'd7, 1'b0, LAT);
        run_case("255/255", 8'd255, 8'd255, 1'b0, 8'd1, 8'd0, 1'b0, LAT);
        run_case("128/3", 8'd128, 8'd3, 1'b0, 8'd42, 8'd2, 1'b0, LAT);

        issue(8'd100, 8'd9, 1'b0);
        n = 0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (done) begin
                n++;
                chk("ign_lat", k, LAT);
                chk("ign_quot", quotient, 8'd11);
                chk("ign_rem", remainder, 8'd1);
            end
            start = (k == 3 || k == 6);
        end
        start = 1'b0;
        chk("ign_count", n, 1);

        issue(8'd200, 8'd7, 1'b0);
        repeat (4) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_quot", quotient, 0);
        chk("abort_rem", remainder, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (done) n++;
        end
        chk("abort_nodone", n, 0);
        run_case("50/5", 8'd50, 8'd5, 1'b0, 8'd10, 8'd0, 1'b0, LAT);

`ifdef SIGNED_DIV_EN
        run_case("s-100/7", 8'h9C, 8'd7, 1'b1, 8'hF2, 8'hFE, 1'b0, LAT);
        run_case("s-128/-1", 8'h80, 8'hFF, 1'b1, 8'h80, 8'h00, 1'b0, LAT);
        run_case("s100/-7", 8'd100, 8'hF9, 1'b1, 8'hF2, 8'h02, 1'b0, LAT);
        run_case("s-5/0", 8'hFB, 8'd0, 1'b1, 8'hFF, 8'hFB, 1'b1, 1);
`endif

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
